// File: rtl/clock_pkg.sv
// Shared constants for the clock time/date setter: field-select encodings,
// packed-bus layout of the time (17b) and date (21b) buses, field ranges,
// and the setter FSM state encoding.
package clock_pkg;

   // Field widths and packed-bus widths
   localparam int unsigned HOUR_W  = 5;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned SEC_W   = 6;
   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;
   localparam int unsigned YEAR_W  = 12;
   localparam int unsigned FLD_W   = 3;
   localparam int unsigned TIME_W  = HOUR_W + MIN_W + SEC_W;
   localparam int unsigned DATE_W  = DAY_W + MONTH_W + YEAR_W;

   // Bit offsets: time = {hour,min,sec}, date = {day,month,year}
   localparam int unsigned SEC_LSB   = 0;
   localparam int unsigned MIN_LSB   = SEC_LSB + SEC_W;
   localparam int unsigned HOUR_LSB  = MIN_LSB + MIN_W;
   localparam int unsigned YEAR_LSB  = 0;
   localparam int unsigned MONTH_LSB = YEAR_LSB + YEAR_W;
   localparam int unsigned DAY_LSB   = MONTH_LSB + MONTH_W;

   // Field-select encodings
   localparam logic [FLD_W-1:0] FLD_HOUR  = 3'd0;
   localparam logic [FLD_W-1:0] FLD_MIN   = 3'd1;
   localparam logic [FLD_W-1:0] FLD_SEC   = 3'd2;
   localparam logic [FLD_W-1:0] FLD_DAY   = 3'd3;
   localparam logic [FLD_W-1:0] FLD_MONTH = 3'd4;
   localparam logic [FLD_W-1:0] FLD_YEAR  = 3'd5;

   // Field ranges
   localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
   localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
   localparam logic [DAY_W-1:0]   DAY_MIN   = 5'd1;
   localparam logic [MONTH_W-1:0] MONTH_MIN = 4'd1;
   localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
   localparam logic [YEAR_W-1:0]  YEAR_MAX  = 12'd4095;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/clock_time_setter_if.sv
// Bus between button/clock-core side and the time setter.
//   buttons   : edit/cancel/next/inc/dec single-cycle pulses
//   time_cur  : running time {hour,min,sec};  date_cur : running date {day,month,year}
//   time_in/date_in : edited values; time_ow/date_ow : overwrite strobes
//   editing   : high while editing;  field_sel : selected field (0 hour .. 5 year)
// master = stimulus/clock side, slave = clock_time_setter.
interface clock_time_setter_if;
   import clock_pkg::*;

   logic              edit_btn;
   logic              cancel_btn;
   logic              next_btn;
   logic              inc_btn;
   logic              dec_btn;
   logic [TIME_W-1:0] time_cur;
   logic [DATE_W-1:0] date_cur;
   logic [TIME_W-1:0] time_in;
   logic [DATE_W-1:0] date_in;
   logic              time_ow;
   logic              date_ow;
   logic              editing;
   logic [FLD_W-1:0]  field_sel;

   modport master (
      output edit_btn, cancel_btn, next_btn, inc_btn, dec_btn, time_cur, date_cur,
      input  time_in, date_in, time_ow, date_ow, editing, field_sel
   );

   modport slave (
      input  edit_btn, cancel_btn, next_btn, inc_btn, dec_btn, time_cur, date_cur,
      output time_in, date_in, time_ow, date_ow, editing, field_sel
   );

endinterface

// File: rtl/clock_days_in_month.sv
// Combinational days-in-month lookup with leap-year handling.
//   month [3:0], year [11:0] in; days [4:0] out.
// Macro GREGORIAN_LEAP_EN: full Gregorian rule; otherwise leap = year divisible by 4.
module clock_days_in_month
   import clock_pkg::*;
(
   input  logic [MONTH_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   output logic [DAY_W-1:0]   days
);

   logic leap;

`ifdef GREGORIAN_LEAP_EN
   always_comb begin
      leap = ((year & YEAR_W'(3)) == '0) &&
             (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
   end
`else
   // Masked compare reduces to the two LSBs; no mod-100/400 logic.
   always_comb begin
      leap = ((year & YEAR_W'(3)) == '0);
   end
`endif

   always_comb begin
      days = 5'd31;
      case (month)
         4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
         4'd2:                    days = leap ? 5'd29 : 5'd28;
         default:                 days = 5'd31;
      endcase
   end

endmodule

// File: rtl/clock_time_setter.sv
// Time/date setter: captures running time/date, lets the user edit each
// field with buttons, and commits via one-cycle time_ow/date_ow strobes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : clock_time_setter_if.slave (buttons, current time/date, edited buses, strobes)
// Parameters: TIMEOUT_CYCLES (0 = no auto-cancel), TIMEOUT_W (counter width).
// Leap rule selected by GREGORIAN_LEAP_EN inside clock_days_in_month.
module clock_time_setter
   import clock_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TIMEOUT_W      = 32
) (
   input logic                clk,
   input logic                rst,
   clock_time_setter_if.slave bus
);

   localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state, state_nxt;
   logic [HOUR_W-1:0]    hour, hour_e, hour_n, cap_hour;
   logic [MIN_W-1:0]     minute, min_e, min_n, cap_min;
   logic [SEC_W-1:0]     sec, sec_e, sec_n, cap_sec;
   logic [DAY_W-1:0]     day, day_e, day_n, cap_day;
   logic [MONTH_W-1:0]   month, month_e, month_n, cap_month;
   logic [YEAR_W-1:0]    year, year_e, year_n, cap_year;
   logic [FLD_W-1:0]     field_sel, field_nxt;
   logic [TIMEOUT_W-1:0] tmo_cnt, cnt_nxt;
   logic                 editing, editing_nxt, strobe, strobe_nxt;
   logic [DAY_W-1:0]     dim_cap, dim_edit;
   logic                 any_btn, field_act, step_inc, step_dec, tmo_hit;

   // Capture path: out-of-range inputs coerced to the field minimum
   always_comb begin
      cap_hour  = bus.time_cur[HOUR_LSB +: HOUR_W];
      cap_min   = bus.time_cur[MIN_LSB +: MIN_W];
      cap_sec   = bus.time_cur[SEC_LSB +: SEC_W];
      cap_month = bus.date_cur[MONTH_LSB +: MONTH_W];
      cap_year  = bus.date_cur[YEAR_LSB +: YEAR_W];
      if (cap_hour > HOUR_MAX) cap_hour = '0;
      if (cap_min > MIN_MAX)   cap_min  = '0;
      if (cap_sec > SEC_MAX)   cap_sec  = '0;
      if (cap_month == '0 || cap_month > MONTH_MAX) cap_month = MONTH_MIN;
   end

   clock_days_in_month u_dim_cap (.month(cap_month), .year(cap_year), .days(dim_cap));

   always_comb begin
      cap_day = bus.date_cur[DAY_LSB +: DAY_W];
      if (cap_day == '0 || cap_day > dim_cap) cap_day = DAY_MIN;
   end

   // Field step decode: only when no higher-priority button is present
   always_comb begin
      any_btn   = bus.edit_btn | bus.cancel_btn | bus.next_btn | bus.inc_btn | bus.dec_btn;
      field_act = (state == ST_EDIT) && !bus.cancel_btn && !bus.edit_btn && !bus.next_btn;
      step_inc  = field_act && bus.inc_btn && !bus.dec_btn;
      step_dec  = field_act && bus.dec_btn && !bus.inc_btn;
      tmo_hit   = TMO_EN && (state == ST_EDIT) && !any_btn && (tmo_cnt == TMO_LAST);
   end

   // Edited hour/min/sec/month/year with wrap-around
   always_comb begin
      hour_e  = hour;
      min_e   = minute;
      sec_e   = sec;
      month_e = month;
      year_e  = year;
      if (step_inc) begin
         case (field_sel)
            FLD_HOUR:  hour_e  = (hour >= HOUR_MAX) ? '0 : hour + HOUR_W'(1);
            FLD_MIN:   min_e   = (minute >= MIN_MAX) ? '0 : minute + MIN_W'(1);
            FLD_SEC:   sec_e   = (sec >= SEC_MAX) ? '0 : sec + SEC_W'(1);
            FLD_MONTH: month_e = (month >= MONTH_MAX) ? MONTH_MIN : month + MONTH_W'(1);
            FLD_YEAR:  year_e  = (year == YEAR_MAX) ? '0 : year + YEAR_W'(1);
            default:   ;
         endcase
      end else if (step_dec) begin
         case (field_sel)
            FLD_HOUR:  hour_e  = (hour == '0) ? HOUR_MAX : hour - HOUR_W'(1);
            FLD_MIN:   min_e   = (minute == '0) ? MIN_MAX : minute - MIN_W'(1);
            FLD_SEC:   sec_e   = (sec == '0) ? SEC_MAX : sec - SEC_W'(1);
            FLD_MONTH: month_e = (month <= MONTH_MIN) ? MONTH_MAX : month - MONTH_W'(1);
            FLD_YEAR:  year_e  = (year == '0) ? YEAR_MAX : year - YEAR_W'(1);
            default:   ;
         endcase
      end
   end

   clock_days_in_month u_dim_edit (.month(month_e), .year(year_e), .days(dim_edit));

   // Day edit; a month/year change clamps the day in the same cycle
   always_comb begin
      day_e = (day > dim_edit) ? dim_edit : day;
      if (step_inc && field_sel == FLD_DAY) day_e = (day >= dim_edit) ? DAY_MIN : day + DAY_W'(1);
      if (step_dec && field_sel == FLD_DAY) day_e = (day <= DAY_MIN) ? dim_edit : day - DAY_W'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      field_nxt = field_sel;
      cnt_nxt   = '0;
      hour_n    = hour;
      min_n     = minute;
      sec_n     = sec;
      day_n     = day;
      month_n   = month;
      year_n    = year;
      unique case (state)
         ST_IDLE: begin
            if (bus.edit_btn) begin
               state_nxt = ST_EDIT;
               field_nxt = FLD_HOUR;
               hour_n    = cap_hour;
               min_n     = cap_min;
               sec_n     = cap_sec;
               day_n     = cap_day;
               month_n   = cap_month;
               year_n    = cap_year;
            end
         end
         ST_EDIT: begin
            if (bus.cancel_btn || tmo_hit) begin
               state_nxt = ST_IDLE;
            end else if (bus.edit_btn) begin
               state_nxt = ST_COMMIT;
            end else begin
               if (bus.next_btn) field_nxt = (field_sel >= FLD_YEAR) ? FLD_HOUR : field_sel + FLD_W'(1);
               hour_n  = hour_e;
               min_n   = min_e;
               sec_n   = sec_e;
               day_n   = day_e;
               month_n = month_e;
               year_n  = year_e;
               if (TMO_EN && !any_btn) cnt_nxt = tmo_cnt + TIMEOUT_W'(1);
            end
         end
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      editing_nxt = (state_nxt == ST_EDIT);
      // Strobe registered from COMMIT: visible the cycle after COMMIT
      strobe_nxt  = (state == ST_COMMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         hour      <= '0;
         minute    <= '0;
         sec       <= '0;
         day       <= '0;
         month     <= '0;
         year      <= '0;
         field_sel <= '0;
         tmo_cnt   <= '0;
         editing   <= 1'b0;
         strobe    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hour      <= hour_n;
         minute    <= min_n;
         sec       <= sec_n;
         day       <= day_n;
         month     <= month_n;
         year      <= year_n;
         field_sel <= field_nxt;
         tmo_cnt   <= cnt_nxt;
         editing   <= editing_nxt;
         strobe    <= strobe_nxt;
      end
   end

   assign bus.time_in   = {hour, minute, sec};
   assign bus.date_in   = {day, month, year};
   assign bus.time_ow   = strobe;
   assign bus.date_ow   = strobe;
   assign bus.editing   = editing;
   assign bus.field_sel = field_sel;

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Writer side of the clock's overwrite interface.
- Lets a user capture the running time/date, edit each field with buttons, then commit.
- Commit drives the packed time_in/date_in buses and one-cycle time_ow/date_ow pulses into the time and calendar counters.
- Sits between the button conditioning logic and the clock/calendar cores.

Parameters:
- TIMEOUT_CYCLES, 0, edit-mode inactivity limit in clk cycles; 0 disables auto-cancel.
- TIMEOUT_W, 32, width of the inactivity counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- edit_btn  in  1  single-cycle pulse; enter edit mode, or commit while editing.
- cancel_btn  in  1  single-cycle pulse; discard the edit.
- next_btn  in  1  single-cycle pulse; advance the selected field.
- inc_btn  in  1  single-cycle pulse; increment the selected field.
- dec_btn  in  1  single-cycle pulse; decrement the selected field.
- time_cur  in  17  running time {hour[4:0],min[5:0],sec[5:0]}.
- date_cur  in  21  running date {day[4:0],month[3:0],year[11:0]}.
- time_in  out  17  edited time, same packing as time_cur.
- date_in  out  21  edited date, same packing as date_cur.
- time_ow  out  1  time overwrite strobe.
- date_ow  out  1  date overwrite strobe.
- editing  out  1  high while in EDIT.
- field_sel  out  3  selected field: 0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - time_in=0, date_in=0, time_ow=0, date_ow=0, editing=0, field_sel=0, timeout counter=0.
  - Reset during EDIT discards the edit; no strobe is emitted.
- States: IDLE, EDIT, COMMIT.
- IDLE:
  - edit_btn: shadow time/date <= time_cur/date_cur; field_sel=0; -> EDIT next cycle.
  - All other buttons are ignored.
- EDIT (editing=1). One action per cycle, priority cancel > edit > next > inc/dec:
  - cancel: -> IDLE, shadows unchanged, no strobe.
  - edit: -> COMMIT.
  - next: field_sel advances 0..5, then wraps to 0.
  - inc and dec in the same cycle: no change.
- Field ranges (inc wraps max->min, dec wraps min->max):
  - hour 0..23.
  - min 0..59.
  - sec 0..59.
  - day 1..days_in_month(month, year).
  - month 1..12.
  - year 0..4095.
- Day clamp: after any month or year change, if day > days_in_month, day is clamped to days_in_month in the same cycle (e.g. 31.03 dec month -> 29.02 on a leap year, 28.02 otherwise).
- Shadow inputs captured out of range (hour>23, min/sec>59, month 0 or >12, day 0 or > days_in_month) are coerced to their field minimum at capture.
- COMMIT: lasts exactly one cycle; time_ow=1 and date_ow=1 together; -> IDLE.
- Latency: edit_btn sampled in EDIT at edge N -> strobes high for the cycle after edge N+1. Strobes are registered outputs.
- time_in/date_in always reflect the shadow registers. They hold their value after commit/cancel until the next capture. The clock cores sample them only on the strobe.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on any button pulse and on EDIT entry.
  - Reaching TIMEOUT_CYCLES-1 in EDIT acts as cancel.
  - Counter is idle outside EDIT.
- days_in_month:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29/28 for February per the leap rule.

Optional Feature:
- GREGORIAN_LEAP_EN defined: leap = (year%4==0) && (year%100!=0 || year%400==0).
- Undefined: leap = (year[1:0]==0) only; no mod-100/400 logic is synthesised.

Decomposition:
- Shared package clock_pkg holds:
  - Field-select encodings (FLD_HOUR..FLD_YEAR).
  - Packed-bus bit offsets and widths for time (17b) and date (21b).
  - Range constants (HOUR_MAX=23, MIN_MAX=59, MONTH_MAX=12, YEAR_MAX=4095).
  - State encodings.
- One sub-module, clock_days_in_month: combinational; month[3:0] and year[11:0] in, days[4:0] out; contains the leap logic and the GREGORIAN_LEAP_EN switch.

Test Plan:
- Capture and commit: time_cur=23:48:00, date_cur=15.01.2020; edit, edit -> one-cycle time_ow=date_ow=1, time_in=17'b10111_110000_000000, date_in=21'b01111_0001_011111100100.
- Field wrap: capture 23:59:59; inc on hour, then next and inc on min, then next and inc on sec -> 00:00:00; dec on hour -> 23.
- Day clamp and leap: 31.03.2000, dec month -> 29.02.2000. With 31.03.1900: GREGORIAN_LEAP_EN defined -> 28.02.1900; undefined -> 29.02.1900.
- Priority: cancel+edit same cycle in EDIT -> IDLE, no strobe; inc+dec together -> no change.
- Timeout: TIMEOUT_CYCLES=16, no buttons after entry -> editing falls after 16 cycles, no strobe; one inc at cycle 10 restarts the count.
- Async reset mid-edit with day edited to 20 -> all outputs 0 immediately, no strobe after reset release.
